branch_resolve_queue: RTL and testbench

//  In-order tracking queue between fetch and execute for conditional branches. Records each

---
 rtl/branch_resolve_queue_pkg.sv | 26 ++
 rtl/branch_resolve_queue_if.sv | 40 ++++
 rtl/branch_resolve_queue_fifo.sv | 65 ++++++
 rtl/branch_resolve_queue.sv | 98 +++++++++
 tb/tb_branch_resolve_queue.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// Shared branch-queue definitions: widths, entry layout and small helpers.
// The branch predictor imports the same package so entry layouts stay in sync.
package branch_resolve_queue_pkg;

    localparam int DEPTH      = 8;
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int XLEN       = 32;
    localparam int INSN_BYTES = 4;
    localparam int ENTRY_W    = XLEN + 1;
    localparam int PRED_BIT   = XLEN;

    typedef logic [XLEN-1:0]  pc_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    // Packed so that the prediction lands on bit PRED_BIT of an ENTRY_W word.
    typedef struct packed {
        logic pred;
        pc_t  pc;
    } brq_entry_t;

    function automatic pc_t next_seq_pc(input pc_t pc);
        return pc + pc_t'(INSN_BYTES);
    endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute-facing bundle of the branch resolve queue.
// master = fetch/execute/predictor side, slave = the queue itself.
interface branch_resolve_queue_if;
    import branch_resolve_queue_pkg::*;

    logic push_valid;
    logic push_ready;
    pc_t  push_pc;
    logic push_pred;

    logic resolve_valid;
    logic resolve_taken;
    pc_t  resolve_target;

    logic update;
    pc_t  update_pc;
    logic taken;
    logic mispredict;

    logic redirect_valid;
    pc_t  redirect_pc;

    cnt_t count;
    logic order_error;

    modport master (
        output push_valid, push_pc, push_pred,
        output resolve_valid, resolve_taken, resolve_target,
        input  push_ready, update, update_pc, taken, mispredict,
        input  redirect_valid, redirect_pc, count, order_error
    );

    modport slave (
        input  push_valid, push_pc, push_pred,
        input  resolve_valid, resolve_taken, resolve_target,
        output push_ready, update, update_pc, taken, mispredict,
        output redirect_valid, redirect_pc, count, order_error
    );

endinterface

// File: rtl/branch_resolve_queue_fifo.sv
// In-order entry storage for the branch queue: circular array, pointers, occupancy.
// flush_i squashes everything behind the entry being popped this cycle.
module brq_fifo
    import branch_resolve_queue_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  brq_entry_t entry_i,
    input  logic       pop_i,
    input  logic       flush_i,
    output brq_entry_t head_o,
    output cnt_t       count_o
);

    brq_entry_t mem_q [DEPTH];
    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    cnt_t       count_q,  count_d;

    // NOTE: the storage array has no reset; occupancy is tracked by count_q, so
    // stale contents are never observed and the array can map to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    // NOTE: every next-state value is defaulted first so no path infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        if (flush_i) begin
            wr_ptr_d = rd_ptr_q + ptr_t'(1);
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            count_d = count_q + cnt_t'(push_i) - cnt_t'(pop_i);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch resolve queue: tracks predicted branches from fetch, trains the
// predictor as execute resolves them, and redirects fetch on a mispredict.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    branch_resolve_queue_if.slave  bus
);

    brq_entry_t head;
    brq_entry_t push_entry;
    cnt_t       count;
    logic       push_ready;
    logic       pop;
    logic       wrong_dir;
    logic       flush;
    logic       push_fire;

    logic update_q,     update_d;
    pc_t  update_pc_q,  update_pc_d;
    logic taken_q,      taken_d;
    logic mispredict_q, mispredict_d;
    logic redirect_q,   redirect_d;
    pc_t  redirect_pc_q, redirect_pc_d;
    logic order_err_q,  order_err_d;

    // A pop never frees space for a same-cycle push, and fetch is held off while
    // it is being redirected.
    assign push_ready = (count != cnt_t'(DEPTH)) && !redirect_q;
    assign pop        = bus.resolve_valid && (count != '0);
    assign wrong_dir  = bus.resolve_taken ^ head.pred;
    assign flush      = pop && wrong_dir;
    // Anything pushed alongside a mispredict is on the wrong path.
    assign push_fire  = bus.push_valid && push_ready && !flush;

    assign push_entry.pc   = bus.push_pc;
    assign push_entry.pred = bus.push_pred;

    brq_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_fire),
        .entry_i (push_entry),
        .pop_i   (pop),
        .flush_i (flush),
        .head_o  (head),
        .count_o (count)
    );

    always_comb begin
        update_d      = pop;
        mispredict_d  = flush;
        redirect_d    = flush;
        update_pc_d   = update_pc_q;
        taken_d       = taken_q;
        redirect_pc_d = redirect_pc_q;
        order_err_d   = order_err_q || (bus.resolve_valid && (count == '0));
        if (pop) begin
            update_pc_d = head.pc;
            taken_d     = bus.resolve_taken;
        end
        if (flush) begin
            redirect_pc_d = bus.resolve_taken ? bus.resolve_target : next_seq_pc(head.pc);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            update_q      <= 1'b0;
            update_pc_q   <= '0;
            taken_q       <= 1'b0;
            mispredict_q  <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            order_err_q   <= 1'b0;
        end else begin
            update_q      <= update_d;
            update_pc_q   <= update_pc_d;
            taken_q       <= taken_d;
            mispredict_q  <= mispredict_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            order_err_q   <= order_err_d;
        end
    end

    assign bus.push_ready     = push_ready;
    assign bus.update         = update_q;
    assign bus.update_pc      = update_pc_q;
    assign bus.taken          = taken_q;
    assign bus.mispredict     = mispredict_q;
    assign bus.redirect_valid = redirect_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.count          = count;
    assign bus.order_error    = order_err_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_branch_resolve_queue;
    import branch_resolve_queue_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_resolve_queue_if bus ();

    branch_resolve_queue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        pc_t  pc;
        logic pred;
    } model_entry_t;

    model_entry_t model_q [$];
    logic e_update, e_taken, e_mis, e_redir, e_err;
    pc_t  e_upc, e_rpc;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        model_q.delete();
        e_update = 1'b0; e_taken = 1'b0; e_mis = 1'b0;
        e_redir  = 1'b0; e_err   = 1'b0;
        e_upc    = '0;   e_rpc   = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".count"}, 64'(bus.count), 64'(model_q.size()));
        check({tag, ".update"}, 64'(bus.update), 64'(e_update));
        check({tag, ".mispredict"}, 64'(bus.mispredict), 64'(e_mis));
        check({tag, ".redirect_valid"}, 64'(bus.redirect_valid), 64'(e_redir));
        check({tag, ".order_error"}, 64'(bus.order_error), 64'(e_err));
        if (e_update) begin
            check({tag, ".update_pc"}, 64'(bus.update_pc), 64'(e_upc));
            check({tag, ".taken"}, 64'(bus.taken), 64'(e_taken));
        end
        if (e_redir) begin
            check({tag, ".redirect_pc"}, 64'(bus.redirect_pc), 64'(e_rpc));
        end
    endtask

    task automatic drive_idle();
        bus.push_valid     = 1'b0;
        bus.push_pc        = '0;
        bus.push_pred      = 1'b0;
        bus.resolve_valid  = 1'b0;
        bus.resolve_taken  = 1'b0;
        bus.resolve_target = '0;
    endtask

    // One clock: drive at the falling edge, predict the edge, check after it.
    task automatic cycle(input string tag, input logic pv, input pc_t ppc, input logic pp,
                         input logic rv, input logic rt, input pc_t rtg);
        model_entry_t h;
        logic exp_ready;
        bus.push_valid     = pv;
        bus.push_pc        = ppc;
        bus.push_pred      = pp;
        bus.resolve_valid  = rv;
        bus.resolve_taken  = rt;
        bus.resolve_target = rtg;
        #1;
        exp_ready = (model_q.size() != DEPTH) && !e_redir;
        check({tag, ".push_ready"}, 64'(bus.push_ready), 64'(exp_ready));

        e_update = 1'b0;
        e_mis    = 1'b0;
        e_redir  = 1'b0;
        if (rv && model_q.size() != 0) begin
            h        = model_q.pop_front();
            e_update = 1'b1;
            e_upc    = h.pc;
            e_taken  = rt;
            if (rt != h.pred) begin
                e_mis   = 1'b1;
                e_redir = 1'b1;
                e_rpc   = rt ? rtg : h.pc + 32'd4;
                model_q.delete();
            end else if (pv && exp_ready) begin
                model_q.push_back('{pc: ppc, pred: pp});
            end
        end else begin
            if (rv) e_err = 1'b1;
            if (pv && exp_ready) model_q.push_back('{pc: ppc, pred: pp});
        end

        @(posedge clk);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic push(input string tag, input pc_t pc, input logic pred);
        cycle(tag, 1'b1, pc, pred, 1'b0, 1'b0, '0);
    endtask

    task automatic resolve(input string tag, input logic rt, input pc_t tgt);
        cycle(tag, 1'b0, '0, 1'b0, 1'b1, rt, tgt);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".count"}, 64'(bus.count), 64'd0);
        check({tag, ".update"}, 64'(bus.update), 64'd0);
        check({tag, ".update_pc"}, 64'(bus.update_pc), 64'd0);
        check({tag, ".taken"}, 64'(bus.taken), 64'd0);
        check({tag, ".mispredict"}, 64'(bus.mispredict), 64'd0);
        check({tag, ".redirect_valid"}, 64'(bus.redirect_valid), 64'd0);
        check({tag, ".redirect_pc"}, 64'(bus.redirect_pc), 64'd0);
        check({tag, ".order_error"}, 64'(bus.order_error), 64'd0);
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        #1;
        check_all_zero("reset");
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset.push_ready", 64'(bus.push_ready), 64'd1);
        @(negedge clk);
    endtask

    task automatic scenario1(input string tag);
        push(tag, 32'h100, 1'b1);
        resolve(tag, 1'b1, 32'h200);
        cycle(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        model_q.delete();
        drive_idle();
        reset = 1'b0;
        @(negedge clk);
        do_reset();

        // 1: correctly predicted taken branch
        scenario1("s1");

        // 2: mispredicts in both directions
        push("s2a", 32'h100, 1'b0);
        resolve("s2a", 1'b1, 32'h80);
        cycle("s2a_after", 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        push("s2b", 32'h104, 1'b1);
        resolve("s2b", 1'b0, 32'h5000);
        cycle("s2b_after", 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        push("s2c", 32'hFFFF_FFFC, 1'b1);
        resolve("s2c_wrap", 1'b0, 32'h0);
        cycle("s2c_after", 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);

        // 3: fill, overfill, pop frees one slot, then wrap the pointers twice
        for (int i = 0; i < DEPTH; i++) push("s3_fill", 32'h1000 + 32'(i * 4), i[0]);
        push("s3_over", 32'hBAD0, 1'b0);
        resolve("s3_pop", model_q[0].pred, 32'h0);
        cycle("s3_ready", 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        for (int r = 0; r < 2; r++) begin
            while (model_q.size() < DEPTH)
                push("s3_refill", 32'h2000 + 32'(r * 256) + 32'(model_q.size() * 4), 1'(r));
            while (model_q.size() != 0)
                resolve("s3_drain", model_q[0].pred, 32'h0);
        end

        // 4: mispredict on a 3-deep queue with a wrong-path push in the same cycle
        for (int i = 0; i < 3; i++) push("s4_fill", 32'h3000 + 32'(i * 4), 1'b1);
        cycle("s4_flush", 1'b1, 32'hDEAD_0000, 1'b1, 1'b1, 1'b0, '0);
        cycle("s4_redir", 1'b1, 32'hDEAD_0004, 1'b1, 1'b0, 1'b0, '0);
        push("s4_post", 32'h3100, 1'b0);
        resolve("s4_post", 1'b0, '0);

        // random traffic against the reference model
        for (int ph = 0; ph < 4; ph++) begin
            for (int n = 0; n < 600; n++) begin
                logic pv, rv, rt;
                pv = ($urandom_range(0, 99) < 30 + ph * 20);
                rv = ($urandom_range(0, 99) < 70 - ph * 15);
                if (model_q.size() != 0)
                    rt = ($urandom_range(0, 9) == 0) ? !model_q[0].pred : model_q[0].pred;
                else
                    rt = 1'($urandom);
                cycle("rand", pv, {$urandom, 2'b00} >> 2 << 2, 1'($urandom), rv, rt, $urandom);
            end
        end

        // 5: resolve on an empty queue is sticky until reset
        do_reset();
        resolve("s5_empty", 1'b1, 32'h40);
        for (int i = 0; i < 3; i++) cycle("s5_hold", 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        push("s5_push", 32'h500, 1'b0);
        resolve("s5_pop", 1'b0, '0);

        // 6: asynchronous reset with 5 entries and a resolve in flight
        do_reset();
        for (int i = 0; i < 5; i++) push("s6_fill", 32'h600 + 32'(i * 4), 1'b0);
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("s6_async");
        model_clear();
        @(posedge clk);
        #1;
        check_all_zero("s6_held");
        drive_idle();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        scenario1("s6_s1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
